// File: rtl/press_replay.sv
// Replays queued single-cycle press events as fixed-width level pulses separated by a guaranteed low gap.
// Optional PRESS_REPLAY_RETRIGGER_EN: a press during HOLD extends the current pulse instead of queueing.
module press_replay #(
  parameter int unsigned CNT_THRESHOLD = 1000000 - 1,
  parameter int unsigned HOLD_TICKS    = 20,
  parameter int unsigned GAP_TICKS     = 10,
  parameter int unsigned PEND_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              press,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned PRESC_W   = (CNT_THRESHOLD > 0) ? $clog2(CNT_THRESHOLD + 1) : 1;
  localparam int unsigned MAX_TICKS = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int unsigned TICK_W    = $clog2(MAX_TICKS + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CNT_THRESHOLD);
  localparam logic [TICK_W-1:0]  HOLD_LAST  = TICK_W'(HOLD_TICKS - 1);
  localparam logic [TICK_W-1:0]  GAP_LAST   = TICK_W'(GAP_TICKS - 1);
  localparam logic [PEND_W-1:0]  PEND_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [PEND_W-1:0]   pending_q, pending_d;
  logic                overflow_q, overflow_d;

  logic tick;
  logic enter_hold;
  logic retrigger;
  logic press_queued;
  logic pop_queue;

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    tick_cnt_d   = tick_cnt_q;
    pending_d    = pending_q;
    overflow_d   = overflow_q;
    enter_hold   = 1'b0;
    retrigger    = 1'b0;
    press_queued = 1'b0;
    pop_queue    = 1'b0;
    tick         = (presc_q == PRESC_LAST);

    case (state_q)
      IDLE: begin
        if (press || (pending_q != '0)) begin
          state_d    = HOLD;
          enter_hold = 1'b1;
        end
      end
      HOLD: begin
        if (tick && (tick_cnt_q == HOLD_LAST)) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (tick && (tick_cnt_q == GAP_LAST)) begin
          if (press || (pending_q != '0)) begin
            state_d    = HOLD;
            enter_hold = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PRESS_REPLAY_RETRIGGER_EN
    if ((state_q == HOLD) && press) begin
      state_d   = HOLD;
      retrigger = 1'b1;
    end
`endif

    // Every phase starts from a clean prescaler so its length is an exact multiple of a tick.
    if ((state_d != state_q) || retrigger || (state_q == IDLE)) begin
      presc_d    = '0;
      tick_cnt_d = '0;
    end else if (tick) begin
      presc_d    = '0;
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end else begin
      presc_d    = presc_q + PRESC_W'(1);
    end

    // A press coinciding with a HOLD entry is that entry's source, so the queue is untouched.
    press_queued = press && !enter_hold && !retrigger;
    pop_queue    = enter_hold && !press;

    if (pop_queue) begin
      pending_d = pending_q - PEND_W'(1);
    end else if (press_queued) begin
      if (pending_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign level_out = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_press_replay.sv
// Scoreboard bench for press_replay: scenarios queue expected pulses and timed status checks,
// and a negedge monitor compares them against what the design presents.
module tb_press_replay;

  localparam int CNT_THRESHOLD = 3;
  localparam int HOLD_TICKS    = 2;
  localparam int GAP_TICKS     = 1;
  localparam int PEND_W        = 2;

  localparam int K_LEVEL    = 0;
  localparam int K_BUSY     = 1;
  localparam int K_PENDING  = 2;
  localparam int K_OVERFLOW = 3;
  localparam int K_PULSES   = 4;
  localparam int K_DRAINED  = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              press = 1'b0;
  logic              level_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  press_replay #(
    .CNT_THRESHOLD(CNT_THRESHOLD),
    .HOLD_TICKS   (HOLD_TICKS),
    .GAP_TICKS    (GAP_TICKS),
    .PEND_W       (PEND_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .press    (press),
    .level_out(level_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int start_c;
    int stop_c;
  } pulse_t;

  typedef struct {
    int    at;
    int    kind;
    int    exp;
    string name;
  } chk_t;

  pulse_t exp_q[$];
  chk_t   chk_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int base     = 0;
  int scen     = 0;
  bit press_at[0:127];
  int reset_at = -1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (scenario %0d, cycle %0d)",
               name, actual, expected, scen, cyc - base);
    end
  endtask

  // Monitor: pairs each observed pulse with the next expected one and runs due status checks.
  int     mon_scen    = 0;
  logic   prev_level  = 1'b0;
  bit     in_pulse    = 1'b0;
  int     pulses_seen = 0;
  pulse_t cur;
  chk_t   c;
  int     rel;
  int     act;

  always @(negedge clk) begin
    if (scen != mon_scen) begin
      mon_scen    = scen;
      prev_level  = 1'b0;
      in_pulse    = 1'b0;
      pulses_seen = 0;
    end
    rel = cyc - base;
    if (mon_scen > 0) begin
      if (level_out === 1'b1 && prev_level !== 1'b1) begin
        pulses_seen++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pulse_start", rel, -1);
        end else begin
          cur      = exp_q.pop_front();
          in_pulse = 1'b1;
          checkOutput("pulse_start", rel, cur.start_c);
        end
      end
      if (level_out !== 1'b1 && prev_level === 1'b1 && in_pulse) begin
        checkOutput("pulse_end", rel - 1, cur.stop_c);
        in_pulse = 1'b0;
      end
      prev_level = level_out;
      while (chk_q.size() > 0 && chk_q[0].at <= rel) begin
        c = chk_q.pop_front();
        case (c.kind)
          K_LEVEL:    act = int'(level_out);
          K_BUSY:     act = int'(busy);
          K_PENDING:  act = int'(pending);
          K_OVERFLOW: act = int'(overflow);
          K_PULSES:   act = pulses_seen;
          default:    act = exp_q.size() + int'(in_pulse);
        endcase
        checkOutput(c.name, act, c.exp);
      end
    end
  end

  task automatic startScenario(input string title);
    reset = 1'b1;
    press = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    base  = cyc;
    for (int i = 0; i < 128; i++) press_at[i] = 1'b0;
    reset_at = -1;
    scen++;
    $display("[TB] scenario %0d: %s", scen, title);
  endtask

  task automatic addPulse(input int s, input int e);
    pulse_t p;
    p.start_c = s;
    p.stop_c  = e;
    exp_q.push_back(p);
  endtask

  task automatic addChk(input int at, input int kind, input int exp, input string name);
    chk_t k;
    k.at   = at;
    k.kind = kind;
    k.exp  = exp;
    k.name = name;
    chk_q.push_back(k);
  endtask

  task automatic applyStimulus(input int last_c);
    for (int r = 0; r <= last_c; r++) begin
      while (cyc - base < r) begin
        @(posedge clk);
        #1;
      end
      press = press_at[r];
      reset = (r == reset_at);
    end
    press = 1'b0;
    reset = 1'b0;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (chk_q.size() != 0 && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (chk_q.size() != 0) begin
      $display("[TB] FAIL drain: %0d checks still queued, expected 0", chk_q.size());
      $fatal(1, "[TB] monitor stalled");
    end
  endtask

  initial begin
    startScenario("single press");
    press_at[10] = 1'b1;
    addPulse(11, 18);
    addChk(5,  K_LEVEL,    0, "reset_level");
    addChk(5,  K_BUSY,     0, "reset_busy");
    addChk(5,  K_PENDING,  0, "reset_pending");
    addChk(5,  K_OVERFLOW, 0, "reset_overflow");
    addChk(11, K_BUSY,     1, "single_busy_start");
    addChk(11, K_PENDING,  0, "single_pending");
    addChk(22, K_BUSY,     1, "single_busy_gap_end");
    addChk(23, K_BUSY,     0, "single_busy_drop");
    addChk(30, K_PULSES,   1, "single_pulse_count");
    addChk(30, K_DRAINED,  0, "single_drained");
    applyStimulus(30);
    waitDrain();

    startScenario("three spaced presses");
    press_at[10] = 1'b1;
    press_at[12] = 1'b1;
    press_at[14] = 1'b1;
    addPulse(11, 18);
    addPulse(23, 30);
    addPulse(35, 42);
    addChk(13, K_PENDING, 1, "three_pending_1");
    addChk(15, K_PENDING, 2, "three_pending_2");
    addChk(20, K_LEVEL,   0, "three_gap_low");
    addChk(23, K_PENDING, 1, "three_pop_1");
    addChk(35, K_PENDING, 0, "three_pop_2");
    addChk(46, K_BUSY,    1, "three_busy_last_gap");
    addChk(47, K_BUSY,    0, "three_busy_drop");
    addChk(50, K_PULSES,  3, "three_pulse_count");
    addChk(50, K_DRAINED, 0, "three_drained");
    applyStimulus(50);
    waitDrain();

    startScenario("five consecutive presses, queue overflow");
    for (int i = 10; i <= 14; i++) press_at[i] = 1'b1;
    addPulse(11, 18);
    addPulse(23, 30);
    addPulse(35, 42);
    addPulse(47, 54);
    addChk(12, K_PENDING,  1, "burst_pending_1");
    addChk(13, K_PENDING,  2, "burst_pending_2");
    addChk(14, K_PENDING,  3, "burst_pending_3");
    addChk(15, K_PENDING,  3, "burst_pending_sat");
    addChk(15, K_OVERFLOW, 1, "burst_overflow_set");
    addChk(23, K_PENDING,  2, "burst_pop_1");
    addChk(35, K_PENDING,  1, "burst_pop_2");
    addChk(47, K_PENDING,  0, "burst_pop_3");
    addChk(59, K_BUSY,     0, "burst_idle");
    addChk(62, K_OVERFLOW, 1, "burst_overflow_sticky");
    addChk(62, K_PULSES,   4, "burst_pulse_count");
    addChk(62, K_DRAINED,  0, "burst_drained");
    applyStimulus(62);
    waitDrain();

    startScenario("press on final gap cycle");
    press_at[10] = 1'b1;
    press_at[22] = 1'b1;
    addPulse(11, 18);
    addPulse(23, 30);
    addChk(19, K_LEVEL,   0, "edge_gap_low");
    addChk(22, K_PENDING, 0, "edge_pending_before");
    addChk(23, K_BUSY,    1, "edge_no_idle");
    addChk(23, K_PENDING, 0, "edge_pending_after");
    addChk(34, K_BUSY,    1, "edge_busy_gap");
    addChk(35, K_BUSY,    0, "edge_busy_drop");
    addChk(38, K_PULSES,  2, "edge_pulse_count");
    addChk(38, K_DRAINED, 0, "edge_drained");
    applyStimulus(38);
    waitDrain();

    startScenario("reset mid-HOLD with queued presses");
    press_at[10] = 1'b1;
    press_at[12] = 1'b1;
    press_at[14] = 1'b1;
    reset_at = 16;
    addPulse(11, 16);
    addChk(15, K_PENDING,  2, "rst_pending_before");
    addChk(16, K_LEVEL,    1, "rst_level_before");
    addChk(17, K_LEVEL,    0, "rst_level_after");
    addChk(17, K_BUSY,     0, "rst_busy_after");
    addChk(17, K_PENDING,  0, "rst_pending_after");
    addChk(17, K_OVERFLOW, 0, "rst_overflow_after");
    addChk(40, K_BUSY,     0, "rst_stays_idle");
    addChk(50, K_PULSES,   1, "rst_pulse_count");
    addChk(50, K_DRAINED,  0, "rst_drained");
    applyStimulus(50);
    waitDrain();

    startScenario("second press during HOLD");
    press_at[10] = 1'b1;
    press_at[15] = 1'b1;
`ifdef PRESS_REPLAY_RETRIGGER_EN
    addPulse(11, 23);
    addChk(16, K_PENDING, 0, "retrig_pending");
    addChk(23, K_LEVEL,   1, "retrig_extended");
    addChk(24, K_LEVEL,   0, "retrig_gap");
    addChk(28, K_BUSY,    0, "retrig_idle");
    addChk(36, K_PULSES,  1, "retrig_pulse_count");
`else
    addPulse(11, 18);
    addPulse(23, 30);
    addChk(16, K_PENDING, 1, "hold_press_queued");
    addChk(23, K_PENDING, 0, "hold_press_popped");
    addChk(35, K_BUSY,    0, "hold_press_idle");
    addChk(36, K_PULSES,  2, "hold_press_pulse_count");
`endif
    addChk(36, K_DRAINED, 0, "hold_press_drained");
    applyStimulus(36);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
